// File: rtl/scan_seq_if.sv
// Handshake and decoder-drive bundle between the scan controller and scan_seq.
interface scan_seq_if;
  logic start;
  logic stop;
  logic mode;
  logic en;
  logic a;
  logic b;
  logic c;
  logic d;
  logic busy;
  logic done;
  logic frame;

  modport master (
    output start, stop, mode,
    input  en, a, b, c, d, busy, done, frame
  );

  modport slave (
    input  start, stop, mode,
    output en, a, b, c, d, busy, done, frame
  );
endinterface

// File: rtl/scan_seq.sv
// Address sequencer for a 4-to-16 decoder scan: steps 0..LAST with DWELL cycles per code.
// Define SCAN_BLANK_EN to compile in a one-cycle en=0 BLANK gap between addresses.
module scan_seq #(
  parameter int unsigned DWELL = 4,
  parameter int unsigned LAST  = 15
) (
  input  logic       clk,
  input  logic       rst,
  scan_seq_if.slave  bus
);

  localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_END   = CW'(DWELL - 1);
  localparam logic [3:0]    ADDR_LAST = 4'(LAST);

`ifdef SCAN_BLANK_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DRIVE = 2'd1, S_BLANK = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DRIVE = 2'd1} state_t;
`endif

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_addr;
  logic          r_en;
  logic          r_busy;
  logic          r_done;
  logic          r_frame;
  logic          r_stop;
  logic          r_mode;

  logic w_slot_end;
  logic w_stop_req;
  logic w_at_last;

  // A stop arriving in the slot-end cycle itself still ends the run at this slot.
  assign w_slot_end = (r_cnt == CNT_END);
  assign w_stop_req = r_stop | bus.stop;
  assign w_at_last  = (r_addr == ADDR_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= 4'd0;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_frame <= 1'b0;
      r_stop  <= 1'b0;
      r_mode  <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_frame <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_en   <= 1'b0;
          r_busy <= 1'b0;
          r_addr <= 4'd0;
          r_cnt  <= '0;
          r_stop <= 1'b0;
          if (bus.start && !bus.stop) begin
            r_state <= S_DRIVE;
            r_en    <= 1'b1;
            r_busy  <= 1'b1;
            r_mode  <= bus.mode;
          end
        end

        S_DRIVE: begin
          if (bus.stop) r_stop <= 1'b1;
          if (!w_slot_end) begin
            r_cnt <= r_cnt + CW'(1);
          end else begin
            r_cnt <= '0;
            if (w_stop_req || (w_at_last && !r_mode)) begin
              // A completed single sweep still reports done even when stopped.
              r_state <= S_IDLE;
              r_en    <= 1'b0;
              r_busy  <= 1'b0;
              r_addr  <= 4'd0;
              r_stop  <= 1'b0;
              r_done  <= w_at_last && !r_mode;
            end else begin
`ifdef SCAN_BLANK_EN
              r_state <= S_BLANK;
              r_en    <= 1'b0;
`else
              r_addr  <= w_at_last ? 4'd0 : r_addr + 4'd1;
              r_frame <= w_at_last;
`endif
            end
          end
        end

`ifdef SCAN_BLANK_EN
        // Address is held through the gap and advances on exit.
        S_BLANK: begin
          if (w_stop_req) begin
            r_state <= S_IDLE;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_addr  <= 4'd0;
            r_stop  <= 1'b0;
          end else begin
            r_state <= S_DRIVE;
            r_en    <= 1'b1;
            r_addr  <= w_at_last ? 4'd0 : r_addr + 4'd1;
            r_frame <= w_at_last;
          end
        end
`endif

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.en    = r_en;
  assign bus.a     = r_addr[3];
  assign bus.b     = r_addr[2];
  assign bus.c     = r_addr[1];
  assign bus.d     = r_addr[0];
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.frame = r_frame;

endmodule

// File: tb/tb_scan_seq.sv
// Bench for scan_seq: three parameterisations, expected outputs from closed-form timing.
module tb_scan_seq;

`ifdef SCAN_BLANK_EN
  localparam int BL = 1;
`else
  localparam int BL = 0;
`endif

  typedef struct packed {
    logic       en;
    logic [3:0] addr;
    logic       busy;
    logic       done;
    logic       frame;
  } obs_t;

  typedef struct {
    int sel;
    bit mode;
    int stop_t;
    int ncyc;
    int exp_done;
    int exp_frame;
    int exp_busy;
  } scen_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  obs_t sb_q[$];
  scen_t tbl[6];

  always #5 clk = ~clk;

  scan_seq_if if0 ();
  scan_seq_if if1 ();
  scan_seq_if if2 ();

  scan_seq #(.DWELL(4), .LAST(15)) u0 (.clk(clk), .rst(rst), .bus(if0));
  scan_seq #(.DWELL(2), .LAST(3))  u1 (.clk(clk), .rst(rst), .bus(if1));
  scan_seq #(.DWELL(1), .LAST(0))  u2 (.clk(clk), .rst(rst), .bus(if2));

  function automatic int dw_of(int sel);
    return (sel == 0) ? 4 : (sel == 1) ? 2 : 1;
  endfunction

  function automatic int last_of(int sel);
    return (sel == 0) ? 15 : (sel == 1) ? 3 : 0;
  endfunction

  function automatic obs_t observe(int sel);
    obs_t o;
    case (sel)
      0: begin o.en = if0.en; o.addr = {if0.a, if0.b, if0.c, if0.d};
               o.busy = if0.busy; o.done = if0.done; o.frame = if0.frame; end
      1: begin o.en = if1.en; o.addr = {if1.a, if1.b, if1.c, if1.d};
               o.busy = if1.busy; o.done = if1.done; o.frame = if1.frame; end
      default: begin o.en = if2.en; o.addr = {if2.a, if2.b, if2.c, if2.d};
               o.busy = if2.busy; o.done = if2.done; o.frame = if2.frame; end
    endcase
    return o;
  endfunction

  // Expected outputs t cycles after the accepting edge; stop_t<0 means no stop.
  function automatic obs_t exp_at(int sel, bit mode, int stop_t, int t);
    int   dw  = dw_of(sel);
    int   lst = last_of(sel);
    int   p   = dw + BL;
    int   f   = (lst + 1) * p;
    int   te  = 1 << 30;
    int   pos;
    obs_t e   = '0;
    if (!mode) te = f - BL;
    if (stop_t >= 0 && ((stop_t / p) * p + dw) < te) te = (stop_t / p) * p + dw;
    if (t < te) begin
      pos     = mode ? (t % f) : t;
      e.busy  = 1'b1;
      e.addr  = 4'(pos / p);
      e.en    = ((pos % p) < dw);
      e.frame = mode && (t >= f) && ((t % f) == 0);
    end else if (t == te) begin
      e.done = !mode && (((te - 1) / p) == lst);
    end
    return e;
  endfunction

  task automatic set_in(int sel, bit st, bit sp, bit md);
    case (sel)
      0:       begin if0.start = st; if0.stop = sp; if0.mode = md; end
      1:       begin if1.start = st; if1.stop = sp; if1.mode = md; end
      default: begin if2.start = st; if2.stop = sp; if2.mode = md; end
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic compare(string name, obs_t got, obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got en=%0b addr=%0d busy=%0b done=%0b frame=%0b, expected en=%0b addr=%0d busy=%0b done=%0b frame=%0b",
               name, got.en, got.addr, got.busy, got.done, got.frame,
               exp.en, exp.addr, exp.busy, exp.done, exp.frame);
    end
  endtask

  task automatic compare_int(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Scoreboard-driven run: expectation queued with each drive, popped at each sample.
  task automatic run_scen(int idx, scen_t s);
    int   n_done  = 0;
    int   n_frame = 0;
    int   n_busy  = 0;
    obs_t got;
    set_in(s.sel, 1'b1, 1'b0, s.mode);
    sb_q.push_back(exp_at(s.sel, s.mode, s.stop_t, 0));
    step();
    for (int t = 0; t < s.ncyc; t++) begin
      got = observe(s.sel);
      compare($sformatf("scen%0d_t%0d", idx, t), got, sb_q.pop_front());
      if (got.done)  n_done++;
      if (got.frame) n_frame++;
      if (got.busy)  n_busy++;
      // mode toggled while busy must have no effect
      set_in(s.sel, 1'b0, (t == s.stop_t), ~s.mode);
      if (t + 1 < s.ncyc) sb_q.push_back(exp_at(s.sel, s.mode, s.stop_t, t + 1));
      step();
    end
    set_in(s.sel, 1'b0, 1'b0, 1'b0);
    compare_int($sformatf("scen%0d_done_count", idx),  n_done,  s.exp_done);
    compare_int($sformatf("scen%0d_frame_count", idx), n_frame, s.exp_frame);
    compare_int($sformatf("scen%0d_busy_cycles", idx), n_busy,  s.exp_busy);
  endtask

  initial begin
    obs_t z = '0;
    set_in(0, 1'b0, 1'b0, 1'b0);
    set_in(1, 1'b0, 1'b0, 1'b0);
    set_in(2, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;

    tbl[0] = '{0, 1'b0, -1,            90, 1, 0,                   (BL != 0) ? 79 : 64};
    tbl[1] = '{1, 1'b1, 34,            45, 0, (BL != 0) ? 2 : 4,   (BL != 0) ? 35 : 36};
    tbl[2] = '{0, 1'b1, 2*(4+BL)+1,    20, 0, 0,                   (BL != 0) ? 14 : 12};
    tbl[3] = '{2, 1'b0, -1,             5, 1, 0,                   1};
    tbl[4] = '{2, 1'b1, 4,             10, 0, (BL != 0) ? 2 : 4,   5};
    tbl[5] = '{0, 1'b0, 15*(4+BL)+1,   90, 1, 0,                   (BL != 0) ? 79 : 64};

    step();
    step();
    compare("reset_u0", observe(0), z);
    compare("reset_u1", observe(1), z);
    compare("reset_u2", observe(2), z);
    rst = 1'b0;
    step();

    // start and stop together in IDLE: stop wins
    set_in(0, 1'b1, 1'b1, 1'b0);
    step();
    set_in(0, 1'b0, 1'b0, 1'b0);
    compare("start_stop_same_cycle", observe(0), z);
    step();
    compare("start_stop_still_idle", observe(0), z);

    // single sweep with a restart attempt while busy, then async reset at addr 5
    set_in(0, 1'b1, 1'b0, 1'b0);
    step();
    for (int t = 0; t <= 5 * (4 + BL) + 1; t++) begin
      compare($sformatf("restart_ignored_t%0d", t), observe(0), exp_at(0, 1'b0, -1, t));
      set_in(0, (t == 3), 1'b0, (t == 3));
      if (t < 5 * (4 + BL) + 1) step();
    end
    compare_int("reset_test_at_addr5", int'(observe(0).addr), 5);
    #2 rst = 1'b1;
    #1 compare("async_reset_mid_sweep", observe(0), z);
    set_in(0, 1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    step();
    compare("idle_after_reset", observe(0), z);

    for (int i = 0; i < 6; i++) begin
      run_scen(i, tbl[i]);
      step();
    end

    // a start sampled in the done cycle is accepted
    set_in(2, 1'b1, 1'b0, 1'b0);
    step();
    set_in(2, 1'b0, 1'b0, 1'b0);
    compare("last0_first_slot", observe(2), exp_at(2, 1'b0, -1, 0));
    step();
    compare("last0_done", observe(2), exp_at(2, 1'b0, -1, 1));
    set_in(2, 1'b1, 1'b0, 1'b0);
    step();
    set_in(2, 1'b0, 1'b0, 1'b0);
    compare("restart_in_done_cycle", observe(2), exp_at(2, 1'b0, -1, 0));
    step();
    compare("restart_done_again", observe(2), exp_at(2, 1'b0, -1, 1));
    step();
    compare("idle_after_second_done", observe(2), z);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
